trb_out_packer: RTL and testbench

Downstream neighbour of the turbo output mux in the NLB AFU turbo decoder. Consumes the mux's 8-bit Avalon-ST stream of fixed 128-byte decoded frames (turbo length 1024 bits) and packs each frame into two 512-bit lines for the AFU write path. Checks framing, resynchronises on sop/eop errors, and buffers lines in a 4-entry FIFO. Back-pressure to the mux is an early, registered ready, because the mux keeps sending bytes for several cycles after ready drops.

---
 rtl/trb_pkg.sv | 19 +
 rtl/trb_line_fifo.sv | 64 ++++++
 rtl/trb_out_packer.sv | 152 +++++++++++++++
 tb/tb_trb_out_packer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trb_pkg.sv
// Shared types and constants for the turbo output packer.
package trb_pkg;

  localparam int FRAME_BYTES = 128;
  localparam int LINE_BYTES  = 64;
  localparam int LINE_W      = 512;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    FILL = 1'b1
  } trb_state_e;

  typedef struct packed {
    logic [LINE_W-1:0] data;
    logic              last;
    logic [15:0]       frame;
  } trb_line_t;

endpackage

// File: rtl/trb_line_fifo.sv
// First-word-fall-through FIFO of packed line records.
// A push while full is only taken when the head is popped in the same cycle.
import trb_pkg::*;

module trb_line_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  trb_line_t                  push_line,
  input  logic                       pop,
  output trb_line_t                  head_line,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  trb_line_t         mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH-1)) return '0;
    return p + 1'b1;
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign occupancy = count;
  // Head is forced to zero when empty so the line outputs idle at zero.
  assign head_line = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Line storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_line;
  end

endmodule

// File: rtl/trb_out_packer.sv
// Packs 128-byte decoded turbo frames from the output mux into two 512-bit
// lines, checks sop/eop framing and buffers lines for the AFU write path.
//
// state | meaning
// ------+-----------------------------------------------------------
// HUNT  | waiting for a sop byte; all other bytes are dropped
// FILL  | inside a frame, cnt is the index of the next expected byte
import trb_pkg::*;

module trb_out_packer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int READY_THRESH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   st_data_in,
  input  logic         st_valid_in,
  input  logic         st_sop_in,
  input  logic         st_eop_in,
  output logic         st_ready_out,
  output logic [511:0] line_data,
  output logic         line_valid,
  output logic         line_last,
  output logic [15:0]  line_frame,
  input  logic         line_ready,
  output logic         err_sop,
  output logic         err_eop,
  output logic         err_overflow
);

  localparam int CNT_W  = $clog2(FRAME_BYTES);
  localparam int LANE_W = $clog2(LINE_BYTES);
  localparam int OCC_W  = $clog2(FIFO_DEPTH+1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES-1);

  trb_state_e        state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [15:0]       frame_cnt, frame_nx;
  logic [LINE_W-1:0] acc, acc_nx;
  logic              sop_err_nx;
  logic              eop_err_nx;
  logic              take;
  logic [CNT_W-1:0]  pos;
  logic              line_push;
  trb_line_t         push_line;
  trb_line_t         head_line;
  logic [OCC_W-1:0]  occupancy;
  logic              fifo_full;
  logic              fifo_empty;

  // Framing decisions for the byte on the input this cycle.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    frame_nx   = frame_cnt;
    acc_nx     = acc;
    sop_err_nx = 1'b0;
    eop_err_nx = 1'b0;
    take       = 1'b0;
    pos        = cnt;
    line_push  = 1'b0;
    if (st_valid_in) begin
      if (state == HUNT) begin
        if (st_sop_in) begin
          take = 1'b1;
          pos  = '0;
        end
      end else if (st_sop_in) begin
        // A sop always restarts at byte 0; mid-frame it aborts the partial frame.
        take = 1'b1;
        pos  = '0;
        if (cnt != '0) begin
          sop_err_nx = 1'b1;
          frame_nx   = frame_nx + 1'b1;
          acc_nx     = '0;
        end
      end else if (cnt == '0) begin
        sop_err_nx = 1'b1;
        state_nx   = HUNT;
      end else begin
        take = 1'b1;
      end

      if (take) begin
        acc_nx[{pos[LANE_W-1:0], 3'b000} +: 8] = st_data_in;
        if (st_eop_in && (pos != LAST_BYTE)) begin
          // Early eop: the frame is abandoned, including its partial line.
          eop_err_nx = 1'b1;
          state_nx   = HUNT;
          cnt_nx     = '0;
          frame_nx   = frame_nx + 1'b1;
        end else begin
          state_nx = FILL;
          cnt_nx   = pos + 1'b1;
          if (pos[LANE_W-1:0] == '1) line_push = 1'b1;
          if (pos == LAST_BYTE) begin
            frame_nx   = frame_nx + 1'b1;
            eop_err_nx = !st_eop_in;
          end
        end
      end
    end
  end

  assign push_line.data  = acc_nx;
  assign push_line.last  = pos[CNT_W-1];
  assign push_line.frame = frame_cnt;

  // Frame state, counters, accumulator, error flags and the ready hint.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= HUNT;
      cnt          <= '0;
      frame_cnt    <= '0;
      acc          <= '0;
      err_sop      <= 1'b0;
      err_eop      <= 1'b0;
      err_overflow <= 1'b0;
      st_ready_out <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      frame_cnt    <= frame_nx;
      acc          <= acc_nx;
      err_sop      <= sop_err_nx;
      err_eop      <= eop_err_nx;
      // Full FIFO means non-empty, so line_ready alone decides whether room opens.
      err_overflow <= err_overflow | (line_push && fifo_full && !line_ready);
      st_ready_out <= (occupancy <= OCC_W'(READY_THRESH));
    end
  end

  trb_line_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (line_push),
    .push_line (push_line),
    .pop       (line_ready),
    .head_line (head_line),
    .occupancy (occupancy),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign line_valid = !fifo_empty;
  assign line_data  = head_line.data;
  assign line_last  = head_line.last;
  assign line_frame = head_line.frame;

endmodule

// File: tb/tb_trb_out_packer.sv
// Self-checking bench for trb_out_packer: scoreboard of expected lines,
// a table of clean frames and hand-written framing/back-pressure sequences.
`timescale 1ns/1ps

module tb_trb_out_packer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   st_data_in = '0;
  logic         st_valid_in = 1'b0;
  logic         st_sop_in = 1'b0;
  logic         st_eop_in = 1'b0;
  logic         st_ready_out;
  logic [511:0] line_data;
  logic         line_valid;
  logic         line_last;
  logic [15:0]  line_frame;
  logic         line_ready = 1'b0;
  logic         err_sop;
  logic         err_eop;
  logic         err_overflow;

  always #5 clk = ~clk;

  trb_out_packer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .st_data_in   (st_data_in),
    .st_valid_in  (st_valid_in),
    .st_sop_in    (st_sop_in),
    .st_eop_in    (st_eop_in),
    .st_ready_out (st_ready_out),
    .line_data    (line_data),
    .line_valid   (line_valid),
    .line_last    (line_last),
    .line_frame   (line_frame),
    .line_ready   (line_ready),
    .err_sop      (err_sop),
    .err_eop      (err_eop),
    .err_overflow (err_overflow)
  );

  typedef struct {
    logic [511:0] data;
    logic         last;
    logic [15:0]  frame;
    bit           chk_frame;
  } exp_line_t;

  typedef struct {
    int seed;
    int mul;
    bit gaps;
    bit rdy_rand;
    bit no_eop;
    int exp_frame;
    int exp_eop_err;
  } vec_t;

  exp_line_t exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int n_err_sop = 0;
  int n_err_eop = 0;
  int n_lines = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int seed, input int mul, input int k);
    return 8'(seed + mul * k);
  endfunction

  // Queue the expected lines of a frame whose byte k is seed + mul*k.
  task automatic expect_frame(input int seed, input int mul, input int fr, input int nlines,
                              input bit chk_frame);
    exp_line_t e;
    for (int l = 0; l < nlines; l++) begin
      e.data = '0;
      for (int b = 0; b < 64; b++) e.data[8*b +: 8] = byte_of(seed, mul, 64*l + b);
      e.last      = (l == 1);
      e.frame     = 16'(fr);
      e.chk_frame = chk_frame;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic sop, input logic eop);
    st_valid_in = 1'b1;
    st_data_in  = d;
    st_sop_in   = sop;
    st_eop_in   = eop;
    @(posedge clk); #1;
    st_valid_in = 1'b0;
    st_sop_in   = 1'b0;
    st_eop_in   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_bytes(input int seed, input int mul, input int start_k, input int n,
                            input bit sop_first, input bit eop_last, input bit gaps,
                            input bit rdy_rand);
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) idle(1);
      if (rdy_rand) line_ready = 1'($urandom_range(0, 1));
      send_byte(byte_of(seed, mul, start_k + i), sop_first && (i == 0), eop_last && (i == n - 1));
    end
  endtask

  task automatic drain(input int budget);
    int waited = 0;
    line_ready = 1'b1;
    while (exp_q.size() != 0 && waited < budget) begin
      @(posedge clk); #1;
      waited++;
    end
    idle(4);
    check("queue_drained", 512'(exp_q.size()), 512'(0));
    check("empty_after_drain", 512'(line_valid), 512'(0));
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    st_valid_in = 1'b0;
    st_sop_in   = 1'b0;
    st_eop_in   = 1'b0;
    idle(2);
    exp_q.delete();
    rst_n = 1'b1;
    idle(1);
    n_err_sop = 0;
    n_err_eop = 0;
    n_lines   = 0;
  endtask

  // Scoreboard and error-pulse monitor, sampled mid-cycle.
  initial begin
    exp_line_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (err_sop) n_err_sop++;
        if (err_eop) n_err_eop++;
        if (line_valid && line_ready) begin
          n_lines++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_line: got frame %0d last %0b, expected no line",
                     line_frame, line_last);
          end else begin
            e = exp_q.pop_front();
            check("line_data", line_data, e.data);
            check("line_last", 512'(line_last), 512'(e.last));
            if (e.chk_frame) check("line_frame", 512'(line_frame), 512'(e.frame));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];

    // Reset state.
    rst_n = 1'b0;
    idle(3);
    check("rst_ready",    512'(st_ready_out), 512'(0));
    check("rst_valid",    512'(line_valid),   512'(0));
    check("rst_last",     512'(line_last),    512'(0));
    check("rst_frame",    512'(line_frame),   512'(0));
    check("rst_data",     line_data,          512'(0));
    check("rst_err_sop",  512'(err_sop),      512'(0));
    check("rst_err_eop",  512'(err_eop),      512'(0));
    check("rst_overflow", 512'(err_overflow), 512'(0));
    rst_n = 1'b1;
    idle(1);
    check("ready_after_reset", 512'(st_ready_out), 512'(1));

    // Single frame 0x00..0x7F with one-cycle line latency.
    line_ready = 1'b1;
    expect_frame(0, 1, 0, 2, 1);
    send_bytes(0, 1, 0, 64, 1, 0, 0, 0);
    check("latency_line0", 512'(line_valid), 512'(1));
    send_bytes(0, 1, 64, 64, 0, 1, 0, 0);
    check("latency_line1", 512'(line_valid), 512'(1));
    drain(50);
    check("single_err_sop", 512'(n_err_sop), 512'(0));
    check("single_err_eop", 512'(n_err_eop), 512'(0));

    // Table of back-to-back clean frames (one with a missing eop).
    vecs[0] = '{8'hA5, 3,   1'b0, 1'b0, 1'b0, 0, 0};
    vecs[1] = '{8'h00, 255, 1'b1, 1'b0, 1'b0, 1, 0};
    vecs[2] = '{8'h3C, 7,   1'b0, 1'b1, 1'b0, 2, 0};
    vecs[3] = '{8'hFF, 1,   1'b0, 1'b0, 1'b1, 3, 1};
    vecs[4] = '{8'h5A, 13,  1'b1, 1'b1, 1'b0, 4, 0};
    do_reset();
    for (int v = 0; v < 5; v++) begin
      n_err_sop = 0;
      n_err_eop = 0;
      line_ready = 1'b1;
      expect_frame(vecs[v].seed, vecs[v].mul, vecs[v].exp_frame, 2, 1);
      send_bytes(vecs[v].seed, vecs[v].mul, 0, 128, 1, !vecs[v].no_eop, vecs[v].gaps,
                 vecs[v].rdy_rand);
      drain(300);
      check("vec_err_sop", 512'(n_err_sop), 512'(0));
      check("vec_err_eop", 512'(n_err_eop), 512'(vecs[v].exp_eop_err));
    end

    // Back-pressure: fill the FIFO, overflow on the fifth line.
    do_reset();
    line_ready = 1'b0;
    expect_frame(1, 1, 0, 2, 1);
    expect_frame(2, 1, 1, 2, 1);
    send_bytes(1, 1, 0, 128, 1, 1, 0, 0);
    check("bp_ready_at_occ2", 512'(st_ready_out), 512'(1));
    idle(1);
    check("bp_ready_fall", 512'(st_ready_out), 512'(0));
    send_bytes(2, 1, 0, 128, 1, 1, 0, 0);
    check("bp_no_overflow_yet", 512'(err_overflow), 512'(0));
    send_bytes(3, 1, 0, 64, 1, 0, 0, 0);
    check("bp_overflow_set", 512'(err_overflow), 512'(1));
    send_bytes(3, 1, 64, 64, 0, 1, 0, 0);
    check("bp_ready_while_full", 512'(st_ready_out), 512'(0));
    drain(100);
    check("bp_overflow_sticky", 512'(err_overflow), 512'(1));
    check("bp_ready_recover", 512'(st_ready_out), 512'(1));
    check("bp_lines", 512'(n_lines), 512'(4));

    // Early sop at cnt=40 of frame 0.
    do_reset();
    line_ready = 1'b1;
    expect_frame(9, 5, 1, 2, 1);
    send_bytes(4, 1, 0, 40, 1, 0, 0, 0);
    send_bytes(9, 5, 0, 128, 1, 1, 0, 0);
    drain(100);
    check("esop_err_sop", 512'(n_err_sop), 512'(1));
    check("esop_err_eop", 512'(n_err_eop), 512'(0));

    // Early eop at cnt=100, then bytes without sop are dropped.
    do_reset();
    line_ready = 1'b1;
    expect_frame(8'h20, 1, 0, 1, 1);
    send_bytes(8'h20, 1, 0, 101, 1, 1, 0, 0);
    send_bytes(8'h77, 1, 0, 20, 0, 0, 0, 0);
    expect_frame(8'h40, 3, 1, 2, 1);
    send_bytes(8'h40, 3, 0, 128, 1, 1, 0, 0);
    drain(100);
    check("eeop_err_sop", 512'(n_err_sop), 512'(0));
    check("eeop_err_eop", 512'(n_err_eop), 512'(1));

    // Missing sop after reset.
    do_reset();
    line_ready = 1'b1;
    send_bytes(8'h11, 1, 0, 10, 0, 0, 0, 0);
    expect_frame(8'h80, 1, 0, 2, 1);
    send_bytes(8'h80, 1, 0, 128, 1, 1, 0, 0);
    drain(100);
    check("nosop_err_sop", 512'(n_err_sop), 512'(0));
    check("nosop_err_eop", 512'(n_err_eop), 512'(0));
    check("nosop_lines", 512'(n_lines), 512'(2));

    // sop and eop on the same mid-frame byte: both errors, back to HUNT.
    do_reset();
    line_ready = 1'b1;
    send_bytes(8'h30, 1, 0, 5, 1, 0, 0, 0);
    send_byte(8'hEE, 1'b1, 1'b1);
    send_bytes(8'h31, 1, 0, 8, 0, 0, 0, 0);
    expect_frame(8'h50, 1, 0, 2, 0);
    send_bytes(8'h50, 1, 0, 128, 1, 1, 0, 0);
    drain(100);
    check("both_err_sop", 512'(n_err_sop), 512'(1));
    check("both_err_eop", 512'(n_err_eop), 512'(1));
    check("both_lines", 512'(n_lines), 512'(2));

    // Reset mid-frame at cnt=70 with one line queued.
    do_reset();
    line_ready = 1'b0;
    send_bytes(8'h60, 1, 0, 70, 1, 0, 0, 0);
    check("rmid_valid_before", 512'(line_valid), 512'(1));
    rst_n = 1'b0;
    idle(1);
    check("rmid_valid_cleared", 512'(line_valid), 512'(0));
    check("rmid_data_cleared", line_data, 512'(0));
    exp_q.delete();
    rst_n = 1'b1;
    idle(1);
    n_lines = 0;
    line_ready = 1'b1;
    expect_frame(8'h90, 1, 0, 2, 1);
    send_bytes(8'h90, 1, 0, 128, 1, 1, 0, 0);
    drain(100);
    check("rmid_lines", 512'(n_lines), 512'(2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
